// File: rtl/trail_pkg.sv
// Shared definitions for the trail frame-buffer writer and reader.
// Contents:
//   dir_t        - bike heading encoding (00 up, 01 down, 10 left, 11 right)
//   PLAY         - Game_State encoding for active play
//   trail_code_t - trail tile codes stored by the writer
//   rd_state_t   - collision reader FSM states
//   cell_addr()  - cell coordinate to frame-buffer word address mapping
package trail_pkg;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      DOWN  = 2'b01,
      LEFT  = 2'b10,
      RIGHT = 2'b11
   } dir_t;

   localparam logic [2:0] PLAY = 3'b010;

   typedef enum logic [2:0] {
      TRAIL_NONE    = 3'd0,
      TRAIL_B_HORIZ = 3'd1,
      TRAIL_B_VERT  = 3'd2,
      TRAIL_R_HORIZ = 3'd3,
      TRAIL_R_VERT  = 3'd4,
      TRAIL_CORNER  = 3'd5
   } trail_code_t;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      REQ_B,
      WAIT_B,
      REQ_R,
      WAIT_R,
      RESOLVE
   } rd_state_t;

   // One frame-buffer row is 640 cells of 2 words each.
   localparam logic [19:0] ROW_PITCH = 20'd1280;

   // Word address of a cell's first word. The offset shifts the playfield
   // into the visible area; the result wraps at 20 bits on purpose so the
   // writer and reader always agree even for out-of-range inputs.
   function automatic logic [19:0] cell_addr(input logic [8:0] nx,
                                             input logic [8:0] ny,
                                             input logic [7:0] ofs);
      logic [19:0] col;
      logic [19:0] row;
      col = 20'(nx) + 20'(ofs);
      row = 20'(ny) + 20'(ofs);
      return (col << 1) + (row * ROW_PITCH);
   endfunction

endpackage

// File: rtl/trail_collision_reader_if.sv
// Frame-buffer read port shared through the OCM arbiter.
// Signals:
//   rd_req  - read request, held until granted
//   rd_addr - word address, stable while rd_req is high
//   rd_gnt  - one-cycle grant from the arbiter
//   rd_data - read word, valid RD_LAT cycles after the grant cycle
// Modports: master (the reader), slave (arbiter / frame buffer side).
interface trail_collision_reader_if;

   logic        rd_req;
   logic [19:0] rd_addr;
   logic        rd_gnt;
   logic [15:0] rd_data;

   modport master (output rd_req, rd_addr, input rd_gnt, rd_data);
   modport slave  (input rd_req, rd_addr, output rd_gnt, rd_data);

endinterface

// File: rtl/next_cell_calc.sv
// Combinational next-head-cell calculator for one bike.
// Ports:
//   x, y  in  current head cell
//   dir   in  heading
//   nx,ny out next cell as 9-bit two's complement
//   wall  out next cell lies outside 0..GRID_MAX on either axis
module next_cell_calc
   import trail_pkg::*;
#(
   parameter int unsigned GRID_MAX = 223
) (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  dir_t       dir,
   output logic [8:0] nx,
   output logic [8:0] ny,
   output logic       wall
);

   localparam logic signed [8:0] LIMIT = 9'(GRID_MAX);

   logic signed [8:0] sx;
   logic signed [8:0] sy;

   // NOTE: every variable gets a value before any conditional update so the
   // block stays purely combinational and no latch is inferred.
   always_comb begin
      sx = $signed({1'b0, x});
      sy = $signed({1'b0, y});
      case (dir)
         UP:      sy = sy - 9'sd1;
         DOWN:    sy = sy + 9'sd1;
         LEFT:    sx = sx - 9'sd1;
         RIGHT:   sx = sx + 9'sd1;
         default: ;
      endcase
      // Both axes are checked: a head already beyond the grid on the axis
      // it is not moving along is still a wall hit.
      wall = (sx < 9'sd0) || (sx > LIMIT) || (sy < 9'sd0) || (sy > LIMIT);
      nx   = sx;
      ny   = sy;
   end

endmodule

// File: rtl/trail_collision_reader.sv
// Trail collision reader: once per frame during play, predicts each bike's
// next head cell, flags wall hits, and reads the cell's first frame-buffer
// word to detect trails. Collision flags are sticky for the current round.
// Ports:
//   Clk, Reset       - system clock, async active-low reset
//   frame_clk        - ~60 Hz frame tick, asynchronous to Clk
//   Game_State       - global game state
//   Blue_*/Red_*     - head cells and headings
//   rd_bus (master)  - frame-buffer read request/grant port
//   collision_blue/red - sticky collision flags
//   check_done       - one-cycle pulse when a frame's check completes
module trail_collision_reader
   import trail_pkg::*;
#(
   parameter int unsigned GRID_MAX   = 223,
   parameter logic [7:0]  BLUE_OFS   = 8'd6,
   parameter logic [7:0]  RED_OFS    = 8'd0,
   parameter int unsigned RD_LAT     = 1,
   parameter logic [15:0] TRAIL_MASK = 16'h0F0F,
   parameter logic [2:0]  PLAY_STATE = PLAY
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic                            frame_clk,
   input  logic [2:0]                      Game_State,
   input  logic [7:0]                      Blue_X,
   input  logic [7:0]                      Blue_Y,
   input  logic [7:0]                      Red_X,
   input  logic [7:0]                      Red_Y,
   input  logic [1:0]                      Blue_dir,
   input  logic [1:0]                      Red_dir,
   trail_collision_reader_if.master        rd_bus,
   output logic                            collision_blue,
   output logic                            collision_red,
   output logic                            check_done
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

   // frame_clk synchronizer (bits 0,1) plus edge-detect history (bit 2).
   logic [2:0] fsync;
   logic       tick;

   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples the pre-edge value of the others.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) fsync <= '0;
      else        fsync <= {fsync[1:0], frame_clk};
   end

   assign tick = fsync[1] & ~fsync[2];

   // Next-cell prediction for both bikes from the live head positions;
   // the results are captured in CALC.
   logic [8:0] b_nx, b_ny, r_nx, r_ny;
   logic       b_wall, r_wall;

   next_cell_calc #(.GRID_MAX(GRID_MAX)) u_blue_next (
      .x    (Blue_X),
      .y    (Blue_Y),
      .dir  (dir_t'(Blue_dir)),
      .nx   (b_nx),
      .ny   (b_ny),
      .wall (b_wall)
   );

   next_cell_calc #(.GRID_MAX(GRID_MAX)) u_red_next (
      .x    (Red_X),
      .y    (Red_Y),
      .dir  (dir_t'(Red_dir)),
      .nx   (r_nx),
      .ny   (r_ny),
      .wall (r_wall)
   );

   rd_state_t   state;
   logic        wall_b, wall_r;
   logic        hit_b, hit_r;
   logic        head_on;
   logic [19:0] addr_r;
   logic [1:0]  lat_cnt;

   // NOTE: the asynchronous reset covers the datapath registers as well as
   // the control state; none of them is a memory array, so all are cheap to
   // reset and nothing downstream can observe stale values after reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state          <= IDLE;
         rd_bus.rd_req  <= 1'b0;
         rd_bus.rd_addr <= '0;
         collision_blue <= 1'b0;
         collision_red  <= 1'b0;
         check_done     <= 1'b0;
         wall_b         <= 1'b0;
         wall_r         <= 1'b0;
         hit_b          <= 1'b0;
         hit_r          <= 1'b0;
         head_on        <= 1'b0;
         addr_r         <= '0;
         lat_cnt        <= '0;
      end else if (Game_State != PLAY_STATE) begin
         // Leaving play abandons any check in flight and ends the round.
         state          <= IDLE;
         rd_bus.rd_req  <= 1'b0;
         collision_blue <= 1'b0;
         collision_red  <= 1'b0;
         check_done     <= 1'b0;
      end else begin
         check_done <= 1'b0;
         case (state)
            IDLE: begin
               // Ticks arriving in any other state are simply not looked at.
               if (tick) state <= CALC;
            end

            CALC: begin
               wall_b  <= b_wall;
               wall_r  <= r_wall;
               hit_b   <= 1'b0;
               hit_r   <= 1'b0;
               head_on <= (b_nx == r_nx) && (b_ny == r_ny);
               addr_r  <= cell_addr(r_nx, r_ny, RED_OFS);
               // A bike heading into a wall needs no frame-buffer lookup.
               if (!b_wall) begin
                  state          <= REQ_B;
                  rd_bus.rd_req  <= 1'b1;
                  rd_bus.rd_addr <= cell_addr(b_nx, b_ny, BLUE_OFS);
               end else if (!r_wall) begin
                  state          <= REQ_R;
                  rd_bus.rd_req  <= 1'b1;
                  rd_bus.rd_addr <= cell_addr(r_nx, r_ny, RED_OFS);
               end else begin
                  state <= RESOLVE;
               end
            end

            REQ_B: begin
               if (rd_bus.rd_gnt) begin
                  rd_bus.rd_req <= 1'b0;
                  lat_cnt       <= 2'd1;
                  state         <= WAIT_B;
               end
            end

            WAIT_B: begin
               // lat_cnt counts cycles since the grant cycle.
               if (lat_cnt == LAT_LAST) begin
                  hit_b <= |(rd_bus.rd_data & TRAIL_MASK);
                  if (!wall_r) begin
                     state          <= REQ_R;
                     rd_bus.rd_req  <= 1'b1;
                     rd_bus.rd_addr <= addr_r;
                  end else begin
                     state <= RESOLVE;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end

            REQ_R: begin
               if (rd_bus.rd_gnt) begin
                  rd_bus.rd_req <= 1'b0;
                  lat_cnt       <= 2'd1;
                  state         <= WAIT_R;
               end
            end

            WAIT_R: begin
               if (lat_cnt == LAT_LAST) begin
                  hit_r <= |(rd_bus.rd_data & TRAIL_MASK);
                  state <= RESOLVE;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end

            RESOLVE: begin
               // Flags only accumulate; they clear when play ends.
               collision_blue <= collision_blue | wall_b | hit_b | head_on;
               collision_red  <= collision_red  | wall_r | hit_r | head_on;
               check_done     <= 1'b1;
               state          <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trail_collision_reader.sv
// Self-checking bench for trail_collision_reader: a table of frame vectors
// plus hand-written sequences for grant stalls, aborts and async reset.
// A small arbiter model grants requests and checks addresses against a
// scoreboard of expected reads.
module tb_trail_collision_reader;
   import trail_pkg::*;

   localparam int CLK_HALF = 10;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [2:0] Game_State;
   logic [7:0] Blue_X, Blue_Y, Red_X, Red_Y;
   logic [1:0] Blue_dir, Red_dir;
   logic       collision_blue, collision_red, check_done;

   trail_collision_reader_if rd_bus ();

   trail_collision_reader dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .frame_clk      (frame_clk),
      .Game_State     (Game_State),
      .Blue_X         (Blue_X),
      .Blue_Y         (Blue_Y),
      .Red_X          (Red_X),
      .Red_Y          (Red_Y),
      .Blue_dir       (Blue_dir),
      .Red_dir        (Red_dir),
      .rd_bus         (rd_bus),
      .collision_blue (collision_blue),
      .collision_red  (collision_red),
      .check_done     (check_done)
   );

   always #CLK_HALF Clk = ~Clk;

   typedef struct {
      logic [7:0]  bx, by;
      logic [1:0]  bd;
      logic [7:0]  rx, ry;
      logic [1:0]  rd;
      logic [15:0] wb, wr;   // frame-buffer words returned for each read
      logic        rb, rr;   // read expected for blue / red
      logic [19:0] ab, ar;   // expected read addresses
      logic        cb, cr;   // expected flags after RESOLVE
   } vec_t;

   typedef struct {
      logic [19:0] addr;
      logic [15:0] data;
   } rd_exp_t;

   vec_t    vecs [8];
   rd_exp_t sb [$];

   int          n_vec = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   int          grants = 0;
   bit          hold_gnt = 1'b0;
   bit          data_due = 1'b0;
   logic [15:0] data_word = 16'h0000;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired", name);
   endtask

   // One clock: observe outputs #1 after the edge, then act as the arbiter
   // and frame buffer for the next edge.
   task automatic step();
      rd_exp_t e;
      @(posedge Clk);
      #1;
      if (check_done) done_cnt++;
      if (data_due) begin
         rd_bus.rd_data = data_word;
         data_due       = 1'b0;
      end else begin
         rd_bus.rd_data = 16'hFFFF;
      end
      if (rd_bus.rd_req && !hold_gnt) begin
         rd_bus.rd_gnt = 1'b1;
         grants++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rd_req: addr 0x%0h, no read expected",
                     rd_bus.rd_addr);
         end else begin
            e = sb.pop_front();
            check("rd_addr", 32'(rd_bus.rd_addr), 32'(e.addr));
            data_word = e.data;
            data_due  = 1'b1;
         end
      end else begin
         rd_bus.rd_gnt = 1'b0;
      end
   endtask

   task automatic load(input vec_t v);
      Blue_X = v.bx; Blue_Y = v.by; Blue_dir = v.bd;
      Red_X  = v.rx; Red_Y  = v.ry; Red_dir  = v.rd;
      if (v.rb) sb.push_back('{addr: v.ab, data: v.wb});
      if (v.rr) sb.push_back('{addr: v.ar, data: v.wr});
   endtask

   // Full frame with immediate grants; checks latency from frame_clk rise
   // (2 sync cycles + 3 fixed + 2 per read) and the resulting flags.
   task automatic run_frame(input vec_t v);
      int n;
      int lat;
      load(v);
      done_cnt  = 0;
      frame_clk = 1'b1;
      n = 0;
      while (done_cnt == 0 && n < 60) begin
         step();
         n++;
         if (n == 4) frame_clk = 1'b0;
      end
      frame_clk = 1'b0;
      if (done_cnt == 0) begin
         fail_now("check_done_timeout");
      end else begin
         lat = 5 + 2 * (int'(v.rb) + int'(v.rr));
         check("latency", 32'(n), 32'(lat));
         check("collision_blue", 32'(collision_blue), 32'(v.cb));
         check("collision_red", 32'(collision_red), 32'(v.cr));
      end
      check("reads_left", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic clear_round();
      Game_State = 3'b001;
      step();
      step();
      check("clear_blue", 32'(collision_blue), 32'd0);
      check("clear_red", 32'(collision_red), 32'd0);
      Game_State = PLAY;
      step();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   n;

      //           bx     by     bd     rx     ry     rd     wb        wr        rb    rr    ab           ar           cb    cr
      vecs[0] = '{8'd10, 8'd20, 2'b11, 8'd50, 8'd60, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 20'd33314,  20'd75620,  1'b0, 1'b0};
      vecs[1] = '{8'd10, 8'd20, 2'b11, 8'd50, 8'd60, 2'b00, 16'h0100, 16'h0000, 1'b1, 1'b1, 20'd33314,  20'd75620,  1'b1, 1'b0};
      vecs[2] = '{8'd0,  8'd5,  2'b10, 8'd223,8'd9,  2'b11, 16'h0000, 16'h0000, 1'b0, 1'b0, 20'd0,      20'd0,      1'b1, 1'b1};
      vecs[3] = '{8'd30, 8'd40, 2'b11, 8'd32, 8'd40, 2'b10, 16'h0000, 16'h0000, 1'b1, 1'b1, 20'd58954,  20'd51262,  1'b1, 1'b1};
      vecs[4] = '{8'd100,8'd0,  2'b00, 8'd5,  8'd5,  2'b01, 16'h0000, 16'hF0F0, 1'b0, 1'b1, 20'd0,      20'd7690,   1'b1, 1'b0};
      vecs[5] = '{8'd200,8'd223,2'b10, 8'd0,  8'd0,  2'b10, 16'h0001, 16'h0000, 1'b1, 1'b0, 20'd293530, 20'd0,      1'b1, 1'b1};
      vecs[6] = '{8'd0,  8'd0,  2'b01, 8'd223,8'd223,2'b00, 16'h8000, 16'h0800, 1'b1, 1'b1, 20'd8972,   20'd284606, 1'b0, 1'b1};
      vecs[7] = '{8'd223,8'd100,2'b11, 8'd0,  8'd223,2'b01, 16'h0000, 16'h0000, 1'b0, 1'b0, 20'd0,      20'd0,      1'b1, 1'b1};

      Reset         = 1'b1;
      frame_clk     = 1'b0;
      Game_State    = 3'b000;
      Blue_X = 0; Blue_Y = 0; Red_X = 0; Red_Y = 0;
      Blue_dir = 0; Red_dir = 0;
      rd_bus.rd_gnt  = 1'b0;
      rd_bus.rd_data = 16'hFFFF;
      #1 Reset = 1'b0;
      #2;
      check("reset_rd_req", 32'(rd_bus.rd_req), 32'd0);
      check("reset_rd_addr", 32'(rd_bus.rd_addr), 32'd0);
      check("reset_collision_blue", 32'(collision_blue), 32'd0);
      check("reset_collision_red", 32'(collision_red), 32'd0);
      check("reset_check_done", 32'(check_done), 32'd0);
      step();
      step();
      @(negedge Clk);
      Reset      = 1'b0;
      Reset      = 1'b1;
      Game_State = PLAY;
      step();
      step();

      // Table-driven frames, each in a fresh round.
      for (int i = 0; i < 8; i++) begin
         clear_round();
         run_frame(vecs[i]);
      end

      // Sticky flag: blue hit persists through a clean frame.
      clear_round();
      run_frame(vecs[1]);
      v    = vecs[0];
      v.cb = 1'b1;
      run_frame(v);

      // Grant stalled 20 cycles in REQ_B; a second tick during it is dropped.
      clear_round();
      load(vecs[0]);
      hold_gnt  = 1'b1;
      done_cnt  = 0;
      frame_clk = 1'b1;
      n = 0;
      while (!rd_bus.rd_req && n < 20) begin
         step();
         n++;
      end
      check("stall_req_seen", 32'(rd_bus.rd_req), 32'd1);
      for (int i = 0; i < 20; i++) begin
         if (i == 1)  frame_clk = 1'b0;
         if (i == 5)  frame_clk = 1'b1;
         if (i == 10) frame_clk = 1'b0;
         step();
         check("stall_rd_req", 32'(rd_bus.rd_req), 32'd1);
         check("stall_rd_addr", 32'(rd_bus.rd_addr), 32'd33314);
      end
      hold_gnt = 1'b0;
      for (int i = 0; i < 40; i++) step();
      check("stall_done_count", 32'(done_cnt), 32'd1);
      check("stall_collision_blue", 32'(collision_blue), 32'd0);
      check("stall_collision_red", 32'(collision_red), 32'd0);
      check("stall_reads_left", 32'(sb.size()), 32'd0);
      sb.delete();

      // Leave PLAY during WAIT_R: abort, flags cleared, no check_done.
      clear_round();
      run_frame(vecs[1]);
      load(vecs[0]);
      grants    = 0;
      done_cnt  = 0;
      frame_clk = 1'b1;
      n = 0;
      while (grants < 2 && n < 30) begin
         step();
         n++;
         if (n == 4) frame_clk = 1'b0;
      end
      frame_clk = 1'b0;
      if (grants < 2) fail_now("abort_red_grant");
      step();                 // now in WAIT_R
      Game_State = 3'b001;
      step();
      check("abort_rd_req", 32'(rd_bus.rd_req), 32'd0);
      check("abort_collision_blue", 32'(collision_blue), 32'd0);
      check("abort_collision_red", 32'(collision_red), 32'd0);
      check("abort_check_done", 32'(check_done), 32'd0);
      for (int i = 0; i < 10; i++) step();
      check("abort_done_count", 32'(done_cnt), 32'd0);
      sb.delete();
      Game_State = PLAY;
      step();
      run_frame(vecs[0]);

      // Async reset in REQ_B with a set flag: outputs drop immediately.
      clear_round();
      run_frame(vecs[1]);
      load(vecs[0]);
      hold_gnt  = 1'b1;
      frame_clk = 1'b1;
      n = 0;
      while (!rd_bus.rd_req && n < 20) begin
         step();
         n++;
      end
      frame_clk = 1'b0;
      check("rst_req_seen", 32'(rd_bus.rd_req), 32'd1);
      #3 Reset = 1'b0;
      #1;
      check("rst_rd_req", 32'(rd_bus.rd_req), 32'd0);
      check("rst_rd_addr", 32'(rd_bus.rd_addr), 32'd0);
      check("rst_collision_blue", 32'(collision_blue), 32'd0);
      check("rst_collision_red", 32'(collision_red), 32'd0);
      check("rst_check_done", 32'(check_done), 32'd0);
      sb.delete();
      hold_gnt = 1'b0;
      data_due = 1'b0;
      step();
      step();
      @(negedge Clk);
      Reset = 1'b1;
      step();
      run_frame(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trail_collision_reader.md
Name: trail_collision_reader

Overview:
- Read-side counterpart of the trail writer.
- Once per frame during PLAY, computes each bike's next head cell and checks it against the walls.
- For each bike not already at a wall, reads that cell's first word from the on-chip trail frame buffer and flags a collision if any trail bits are set.
- Shares the frame-buffer read port through a request/grant handshake and feeds sticky collision flags to the game-state controller.

Parameters:
- GRID_MAX, 223: highest legal cell coordinate on both axes (448-pixel area, 2-pixel cells).
- BLUE_OFS, 6: coordinate offset added to blue X/Y before address mapping (matches the writer).
- RED_OFS, 0: coordinate offset added to red X/Y before address mapping.
- RD_LAT, 1: cycles from the grant cycle to rd_data valid; legal range 1–3.
- TRAIL_MASK, 16'h0F0F: bits of a frame-buffer word that mark occupancy.
- PLAY_STATE, 3'b010: Game_State encoding for active play.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  ~60 Hz frame tick, asynchronous to Clk.
- Game_State  in  3  global game state.
- Blue_X, Blue_Y, Red_X, Red_Y  in  8 each  current head cells.
- Blue_dir, Red_dir  in  2 each  heading: 00 up, 01 down, 10 left, 11 right.
- rd_req  out  1  frame-buffer read request.
- rd_addr  out  20  read address; stable while rd_req is high.
- rd_gnt  in  1  one-cycle grant from the OCM arbiter.
- rd_data  in  16  frame-buffer word, valid RD_LAT cycles after the grant cycle.
- collision_blue, collision_red  out  1 each  sticky collision flags.
- check_done  out  1  one-cycle pulse when a frame's check completes.

Behaviour:
- Reset (async assert, sync release): state IDLE; rd_req=0, rd_addr=0, both flags=0, check_done=0; edge-detect history cleared.
- frame_clk handling:
  - Passes through a 2-flop synchronizer, then a rising-edge detect producing a one-cycle tick.
  - Ticks arriving while not in IDLE are dropped.
- Leaving PLAY (Game_State != PLAY_STATE) at any time: synchronously return to IDLE, drop rd_req, clear both flags. Flags therefore persist only within a round.
- Next-cell arithmetic, 9-bit signed:
  - up: Y-1; down: Y+1; left: X-1; right: X+1.
  - Wall hit if the result is <0 or >GRID_MAX.
- Address mapping, 20-bit unsigned, truncated: addr = (nx+OFS)*2 + 1280*(ny+OFS).
- FSM:
  - IDLE: on tick with Game_State==PLAY_STATE -> CALC.
  - CALC (1 cycle): latch inputs; compute both next cells, wall flags and addresses; set head_on if both next cells are equal. -> REQ_B, or REQ_R if blue hit a wall.
  - REQ_B: rd_req=1, rd_addr=blue address; hold until rd_gnt, then -> WAIT_B.
  - WAIT_B: count RD_LAT cycles after grant, sample rd_data; blue_hit = |(rd_data & TRAIL_MASK). -> REQ_R, or RESOLVE if red hit a wall.
  - REQ_R / WAIT_R: same as REQ_B / WAIT_B with the red address; red_hit.
  - RESOLVE (1 cycle): collision_x |= wall_x | hit_x | head_on; pulse check_done. -> IDLE.
- rd_req deasserts in the cycle after rd_gnt is seen.
- A grant seen while rd_req=0 is ignored.
- No timeout: the FSM waits indefinitely for rd_gnt.
- Flags only set (never clear) within PLAY; both may set in the same RESOLVE.
- Latency with immediate grant and RD_LAT=1: tick to check_done = 7 cycles.

Decomposition:
- Package trail_pkg:
  - direction enum (UP, DOWN, LEFT, RIGHT);
  - game-state constants (PLAY=3'b010);
  - trail codes 0–5 (none, B_HORIZ, B_VERT, R_HORIZ, R_VERT, CORNER);
  - the cell-to-address function, so writer and reader share one mapping.
- Sub-module next_cell_calc: combinational; takes X, Y, dir; returns nx, ny, wall.
  - Instantiated twice.

Test Plan:
- Blue (10,20) right, red (50,60) up, rd_data=0, immediate grant:
  - rd_addr=33314 then 75620;
  - check_done 7 cycles after tick;
  - both flags 0.
- Same positions, rd_data=16'h0100 on the blue read:
  - collision_blue=1, collision_red=0;
  - flag stays 1 on next tick with rd_data=0.
- Blue (0,5) left, red (223,9) right:
  - no rd_req at all;
  - both flags 1 after RESOLVE.
- Blue (30,40) right, red (32,40) left, rd_data=0:
  - next cells equal (31,40);
  - both flags 1.
- Hold rd_gnt low 20 cycles in REQ_B:
  - rd_req/rd_addr stable throughout;
  - a second tick during the wait is dropped;
  - exactly one check_done.
- Game_State -> 3'b001 mid-WAIT_R: IDLE next cycle, rd_req=0, flags=0.
- Async Reset low mid-REQ_B: outputs 0 immediately.
